// File: rtl/serial_subtractor_pkg.sv
// Shared constants, state encoding and flag helper for the digit-serial subtractor.
package serial_subtractor_pkg;

   localparam int NBIT  = 32;
   localparam int DIGIT = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Signed overflow of a - b, from the two operand sign bits and the result sign bit.
   function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// One DIGIT-wide slice of a - b - bin with the borrow rippled bit by bit.
module sub_digit #(
   parameter int DIGIT = serial_subtractor_pkg::DIGIT
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             bin,
   output logic [DIGIT-1:0] d,
   output logic             bout
);

   logic [DIGIT:0] br;

   always_comb begin
      br    = '0;
      br[0] = bin;
      d     = '0;
      for (int i = 0; i < DIGIT; i++) begin
         d[i]    = a[i] ^ b[i] ^ br[i];
         br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
      end
   end

   assign bout = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor s = a - b, DIGIT bits per clock, LSB first, start/ready/done handshake.
// Define SUB_FLAGS_EN to add the registered borrow/zero/ovf outputs.
module serial_subtractor #(
   parameter int NBIT  = serial_subtractor_pkg::NBIT,
   parameter int DIGIT = serial_subtractor_pkg::DIGIT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [NBIT-1:0] a,
   input  logic [NBIT-1:0] b,
   output logic            ready,
   output logic            done,
   output logic [NBIT-1:0] s
`ifdef SUB_FLAGS_EN
   ,
   output logic            borrow,
   output logic            zero,
   output logic            ovf
`endif
);

   import serial_subtractor_pkg::*;

   localparam int NSTEP = NBIT / DIGIT;
   localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

   state_t state, state_nx;

   logic [CNT_W-1:0]      cnt;
   logic [NBIT-1:0]       a_sh, b_sh, r_sh;
   logic                  brw;
   logic [DIGIT-1:0]      d;
   logic                  bout;
   logic [NBIT+DIGIT-1:0] cat;
   logic [NBIT-1:0]       res_nx;
   logic                  accept;
   logic                  last;

   assign accept = start & ready;
   assign last   = (state == S_RUN) && (cnt == CNT_LAST);

   sub_digit #(.DIGIT(DIGIT)) u_digit (
      .a    (a_sh[DIGIT-1:0]),
      .b    (b_sh[DIGIT-1:0]),
      .bin  (brw),
      .d    (d),
      .bout (bout)
   );

   // New digit enters at the MSB end; after NSTEP shifts the LSB digit has reached bit 0.
   assign cat    = {d, r_sh};
   assign res_nx = cat[NBIT+DIGIT-1:DIGIT];

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      done     = 1'b0;
      unique case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) state_nx = S_RUN;
         end
         S_RUN: begin
            if (cnt == CNT_LAST) state_nx = S_DONE;
         end
         S_DONE: begin
            ready    = 1'b1;
            done     = 1'b1;
            state_nx = start ? S_RUN : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand shift registers carry no meaning until an accept reloads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh <= a;
         b_sh <= b;
      end else if (state == S_RUN) begin
         a_sh <= a_sh >> DIGIT;
         b_sh <= b_sh >> DIGIT;
         r_sh <= res_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         brw <= 1'b0;
         s   <= '0;
      end else if (accept) begin
         cnt <= '0;
         brw <= 1'b0;
      end else if (state == S_RUN) begin
         cnt <= cnt + 1'b1;
         brw <= bout;
         if (last) s <= res_nx;
      end
   end

`ifdef SUB_FLAGS_EN
   logic sa, sb;

   always_ff @(posedge clk) begin
      if (rst) begin
         sa     <= 1'b0;
         sb     <= 1'b0;
         borrow <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         sa <= a[NBIT-1];
         sb <= b[NBIT-1];
      end else if (last) begin
         borrow <= bout;
         zero   <= (res_nx == '0);
         ovf    <= sub_ovf(sa, sb, d[DIGIT-1]);
      end
   end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor at NBIT=8, DIGIT=2.
module tb_serial_subtractor;

   localparam int NB = 8;
   localparam int DG = 2;
   localparam int N  = NB / DG;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NB-1:0] a, b;
   logic          ready, done;
   logic [NB-1:0] s;
`ifdef SUB_FLAGS_EN
   logic          borrow, zero, ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.NBIT(NB), .DIGIT(DG)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .done   (done),
      .s      (s)
`ifdef SUB_FLAGS_EN
      ,
      .borrow (borrow),
      .zero   (zero),
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] s;
      logic       brw;
      logic       zr;
      logic       ov;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Counts cycles until done is seen, giving up after 20.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run_op(input logic [7:0] va, input logic [7:0] vb);
      int c;
      a     = va;
      b     = vb;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ready_drop", 32'(ready), 32'd0);
      wait_done(c);
      chk("latency", 32'(c), 32'(N));
   endtask

   initial begin
      int  c;
      bit  seen;

      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s", 32'(s), 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b);
         chk("s", 32'(s), 32'(vecs[i].s));
`ifdef SUB_FLAGS_EN
         chk("borrow", 32'(borrow), 32'(vecs[i].brw));
         chk("zero", 32'(zero), 32'(vecs[i].zr));
         chk("ovf", 32'(ovf), 32'(vecs[i].ov));
`endif
         tick();
         chk("done_pulse", 32'(done), 32'd0);
         chk("s_hold", 32'(s), 32'(vecs[i].s));
      end

      // start during RUN is dropped and cannot disturb the running operands
      a     = 8'h10;
      b     = 8'h01;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a     = 8'hFF;
      b     = 8'hFF;
      start = 1'b1;
      chk("busy_ready", 32'(ready), 32'd0);
      tick();
      start = 1'b0;
      wait_done(c);
      chk("ign_latency", 32'(c + 2), 32'(N));
      chk("ign_s", 32'(s), 32'h0F);
      tick();

      // start held high: back-to-back ops every N+1 cycles
      a     = 8'h21;
      b     = 8'h10;
      start = 1'b1;
      tick();
      wait_done(c);
      chk("b2b_first", 32'(c), 32'(N));
      chk("b2b_s0", 32'(s), 32'h11);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("b2b_ready", 32'(ready), 32'd0);
         chk("b2b_s_run", 32'(s), 32'h11);
         wait_done(c);
         chk("b2b_gap", 32'(c + 1), 32'(N + 1));
         chk("b2b_s", 32'(s), 32'h11);
      end
      start = 1'b0;
      tick();

      // reset two cycles into RUN aborts the op
      a     = 8'h33;
      b     = 8'h11;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_s", 32'(s), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);

      run_op(8'h44, 8'h11);
      chk("post_abort_s", 32'(s), 32'h33);
`ifdef SUB_FLAGS_EN
      chk("post_abort_borrow", 32'(borrow), 32'd0);
      chk("post_abort_zero", 32'(zero), 32'd0);
      chk("post_abort_ovf", 32'(ovf), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
